// File: rtl/csa_accum_if.sv
// Handshake bundle between a csa stage and the carry-save accumulator.
interface csa_accum_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned CNT_WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_sum;
  logic [WIDTH-1:0]     in_carry;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 busy;

  // Producer of beats / consumer of results.
  modport master (
    output in_valid, in_sum, in_carry, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_sum, in_carry, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/csa_accum.sv
// Carry-save accumulator: merges redundant (sum, carry) beats without carry
// propagation, then resolves the total with a chunked multi-cycle adder.
module csa_accum #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ACC_WIDTH = 8,
  parameter int unsigned CHUNK     = 2,
  parameter int unsigned CNT_WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  csa_accum_if.slave bus
);
  localparam int unsigned NumChunks = ACC_WIDTH / CHUNK;
  localparam int unsigned KW        = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  typedef enum logic [1:0] {StAcc, StResolve, StDone} state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] acc_s_q;
  logic [ACC_WIDTH-1:0] acc_c_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic [CNT_WIDTH-1:0] out_count_q;
  logic [KW-1:0]        chunk_q;
  logic                 chunk_cy_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [ACC_WIDTH-1:0] ext_sum;
  logic [ACC_WIDTH-1:0] ext_carry;
  logic [ACC_WIDTH-1:0] l1_s;
  logic [ACC_WIDTH-1:0] l1_c_sh;
  logic [ACC_WIDTH-1:0] l2_s;
  logic [ACC_WIDTH-1:0] l2_c_sh;
  logic [CHUNK:0]       chunk_add;
  logic                 accept;

  // Two 3:2 layers; carries are formed already shifted so the MSB carry drops out.
  always_comb begin
    ext_sum   = ACC_WIDTH'(bus.in_sum);
    ext_carry = ACC_WIDTH'({bus.in_carry, 1'b0});
    l1_s      = acc_s_q ^ acc_c_q ^ ext_sum;
    l1_c_sh   = {(acc_s_q[ACC_WIDTH-2:0] & acc_c_q[ACC_WIDTH-2:0]) |
                 (acc_s_q[ACC_WIDTH-2:0] & ext_sum[ACC_WIDTH-2:0]) |
                 (acc_c_q[ACC_WIDTH-2:0] & ext_sum[ACC_WIDTH-2:0]), 1'b0};
    l2_s      = l1_s ^ l1_c_sh ^ ext_carry;
    l2_c_sh   = {(l1_s[ACC_WIDTH-2:0] & l1_c_sh[ACC_WIDTH-2:0]) |
                 (l1_s[ACC_WIDTH-2:0] & ext_carry[ACC_WIDTH-2:0]) |
                 (l1_c_sh[ACC_WIDTH-2:0] & ext_carry[ACC_WIDTH-2:0]), 1'b0};
    chunk_add = {1'b0, acc_s_q[chunk_q*CHUNK +: CHUNK]} +
                {1'b0, acc_c_q[chunk_q*CHUNK +: CHUNK]} +
                (CHUNK+1)'(chunk_cy_q);
    accept    = bus.in_valid && in_ready_q;
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StAcc;
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      chunk_q     <= '0;
      chunk_cy_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            acc_s_q <= l2_s;
            acc_c_q <= l2_c_sh;
            if (out_count_q != '1) out_count_q <= out_count_q + CNT_WIDTH'(1);
            if (bus.in_last) begin
              state_q    <= StResolve;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              chunk_q    <= '0;
              chunk_cy_q <= 1'b0;
            end
          end
        end
        StResolve: begin
          out_data_q[chunk_q*CHUNK +: CHUNK] <= chunk_add[CHUNK-1:0];
          chunk_cy_q <= chunk_add[CHUNK];
          if (chunk_q == KW'(NumChunks - 1)) begin
            chunk_q     <= '0;
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end else begin
            chunk_q <= chunk_q + KW'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StAcc;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            chunk_cy_q  <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= StAcc;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_csa_accum.sv
// Bench for csa_accum: table of accumulations, scoreboarded results, and
// hand-written backpressure / flood / mid-resolve reset sequences.
module tb_csa_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   last_acc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  csa_accum_if #(.WIDTH(4), .ACC_WIDTH(8), .CNT_WIDTH(8)) bus ();

  csa_accum #(.WIDTH(4), .ACC_WIDTH(8), .CHUNK(2), .CNT_WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int             n;
    logic [7:0][3:0] s;
    logic [7:0][3:0] c;
    logic [7:0]     exp_data;
    logic [7:0]     exp_cnt;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] cnt;
  } res_t;

  vec_t tbl[6];
  res_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Results are compared on the cycle the handshake will complete.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !prev_valid) chk("latency", cyc - last_acc, 4);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          res_t r;
          r = sb.pop_front();
          chk("out_data", {24'h0, bus.out_data}, {24'h0, r.data});
          chk("out_count", {24'h0, bus.out_count}, {24'h0, r.cnt});
        end
      end
    end
    prev_valid <= rst_n && bus.out_valid;
  end

  task automatic send(input int idx, input bit push, input bit flood);
    int k;
    for (int i = 0; i < tbl[idx].n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = tbl[idx].s[i % 8];
      bus.in_carry = tbl[idx].c[i % 8];
      bus.in_last  = (i == tbl[idx].n - 1);
      if (bus.in_last && push) sb.push_back('{data: tbl[idx].exp_data, cnt: tbl[idx].exp_cnt});
      k = 0;
      while (!bus.in_ready && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
      if (k >= 50) chk("accept_timeout", 1, 0);
      @(posedge clk); #1;
    end
    last_acc = cyc;
    bus.in_last = 1'b0;
    if (flood) begin
      bus.in_sum   = 4'hF;
      bus.in_carry = 4'hF;
      k = 0;
      while (!bus.out_valid && k < 50) begin
        chk("flood_in_ready", {31'h0, bus.in_ready}, 0);
        @(posedge clk); #1;
        k++;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(bus.in_ready && !bus.busy) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk("idle_timeout", 1, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'h0, bus.out_valid}, 0);
    chk({tag, "_out_data"}, {24'h0, bus.out_data}, 0);
    chk({tag, "_out_count"}, {24'h0, bus.out_count}, 0);
    chk({tag, "_in_ready"}, {31'h0, bus.in_ready}, 1);
    chk({tag, "_busy"}, {31'h0, bus.busy}, 0);
  endtask

  initial begin
    int k;
    // Beat lists are packed {b7..b0}; beat 0 is the rightmost nibble.
    tbl[0] = '{n: 3, s: {20'h0, 4'hC, 4'hC, 4'h7}, c: {20'h0, 4'h3, 4'h3, 4'h1},
               exp_data: 8'h2D, exp_cnt: 8'd3};
    tbl[1] = '{n: 6, s: {8{4'hF}}, c: {8{4'hF}}, exp_data: 8'h0E, exp_cnt: 8'd6};
    tbl[2] = '{n: 1, s: {8{4'h1}}, c: {8{4'h0}}, exp_data: 8'h01, exp_cnt: 8'd1};
    tbl[3] = '{n: 300, s: {8{4'h1}}, c: {8{4'h0}}, exp_data: 8'h2C, exp_cnt: 8'hFF};
    tbl[4] = '{n: 4, s: {16'h0, 4'h0, 4'h3, 4'h5, 4'hA}, c: {16'h0, 4'h1, 4'h8, 4'hF, 4'h2},
               exp_data: 8'h46, exp_cnt: 8'd4};
    tbl[5] = '{n: 1, s: {8{4'h2}}, c: {8{4'h1}}, exp_data: 8'h04, exp_cnt: 8'd1};

    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_carry  = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      send(i, 1'b1, 1'b0);
      wait_idle();
    end

    // Input held valid during RESOLVE must be ignored.
    send(0, 1'b1, 1'b1);
    wait_idle();

    // Backpressure in DONE.
    bus.out_ready = 1'b0;
    send(0, 1'b1, 1'b0);
    k = 0;
    while (!bus.out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("bp_valid_timeout", 1, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", {31'h0, bus.out_valid}, 1);
      chk("bp_out_data", {24'h0, bus.out_data}, 32'h2D);
      chk("bp_out_count", {24'h0, bus.out_count}, 3);
      chk("bp_in_ready", {31'h0, bus.in_ready}, 0);
      chk("bp_busy", {31'h0, bus.busy}, 1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'h0, bus.in_ready}, 1);
    send(2, 1'b1, 1'b0);
    wait_idle();

    // Reset during the second RESOLVE cycle aborts the result.
    send(0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(5, 1'b1, 1'b0);
    wait_idle();

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
